// File: rtl/vga_char_seq_if.sv
// Bus bundle for the character sequencer: pixel coordinates, character RAM,
// font ROM and host write port. The sequencer is the slave; its environment is the master.
`timescale 1ns/1ps
interface vga_char_seq_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        disp_en;
  logic [15:0] pix_data;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        wr_req;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;

  modport master (
    output pix_x, pix_y, disp_en, ram_rdata, font_data, wr_req, wr_addr, wr_data,
    input  pix_data, ram_addr, ram_we, ram_wdata, font_addr, wr_ack
  );

  modport slave (
    input  pix_x, pix_y, disp_en, ram_rdata, font_data, wr_req, wr_addr, wr_data,
    output pix_data, ram_addr, ram_we, ram_wdata, font_addr, wr_ack
  );
endinterface

// File: rtl/vga_char_seq.sv
// Character-mode pixel sequencer: fetches char codes and glyph rows on a fixed
// 3-cycle pipeline and slips host writes into RAM cycles not used by display fetches.
`timescale 1ns/1ps
module vga_char_seq #(
  parameter int unsigned CHAR_W = 8,
  parameter int unsigned CHAR_H = 16,
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter logic [15:0] FG     = 16'hFFFF,
  parameter logic [15:0] BG     = 16'h0000
) (
  input  logic          vga_clk,
  input  logic          rst,
  vga_char_seq_if.slave bus
);

  localparam int unsigned ACT_W = COLS * CHAR_W;
  localparam int unsigned ACT_H = ROWS * CHAR_H;
  localparam int unsigned CELLS = COLS * ROWS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state, state_nxt;
  logic        active0, slot0, addr_ok;
  logic [11:0] cell_addr0;
  logic [3:0]  grow0;
  logic        act1, slot1, act2, slot2;
  logic [2:0]  off1, off2;
  logic [3:0]  grow1;
  logic [7:0]  glyph_q, glyph_cur;
  logic        pix_bit;

  // Stage 0: decode coordinate into cell address and glyph row
  always_comb begin
    active0    = !rst && bus.disp_en && (32'(bus.pix_x) < ACT_W) && (32'(bus.pix_y) < ACT_H);
    slot0      = active0 && (bus.pix_x[2:0] == 3'd0);
    cell_addr0 = 12'((32'(bus.pix_y) / CHAR_H) * COLS + 32'(bus.pix_x) / CHAR_W);
    grow0      = 4'(32'(bus.pix_y) % CHAR_H);
    addr_ok    = 32'(bus.wr_addr) < CELLS;
  end

  // Char code arrives one cycle after the slot and addresses the font ROM directly
  assign bus.font_addr = rst ? 12'd0 : {bus.ram_rdata, grow1};

  // Slot pixel takes the fresh ROM byte; the rest of the cell uses the staged copy
  assign glyph_cur = slot2 ? bus.font_data : glyph_q;
  assign pix_bit   = glyph_cur[~off2];

  // Pixel pipeline: offset and active flag travel alongside the fetch
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      act1         <= 1'b0;
      slot1        <= 1'b0;
      off1         <= 3'd0;
      grow1        <= 4'd0;
      act2         <= 1'b0;
      slot2        <= 1'b0;
      off2         <= 3'd0;
      glyph_q      <= 8'd0;
      bus.pix_data <= BG;
    end else begin
      act1         <= active0;
      slot1        <= slot0;
      off1         <= bus.pix_x[2:0];
      grow1        <= grow0;
      act2         <= act1;
      slot2        <= slot1;
      off2         <= off1;
      if (slot2) glyph_q <= bus.font_data;
      bus.pix_data <= (act2 && pix_bit) ? FG : BG;
    end
  end

  // Host FSM state register
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Host FSM next state: WAIT retires on the first non-slot cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.wr_req) state_nxt = S_WAIT;
      S_WAIT:  if (!slot0) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // RAM port mux: display fetch always owns the slot cycle
  always_comb begin
    bus.ram_addr  = 12'd0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = 8'd0;
    bus.wr_ack    = (state == S_ACK);
    if (slot0) begin
      bus.ram_addr = cell_addr0;
    end else if (state == S_WAIT && addr_ok) begin
      bus.ram_we    = 1'b1;
      bus.ram_addr  = bus.wr_addr;
      bus.ram_wdata = bus.wr_data;
    end
  end

endmodule

// File: tb/tb_vga_char_seq.sv
// Directed bench for vga_char_seq with RAM/ROM models, a shadow character map
// and a per-cycle pixel checker working from coordinates three cycles earlier.
`timescale 1ns/1ps
module tb_vga_char_seq;

  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h0000;
  localparam int CELLS = 2400;
  localparam int IDLE_XY = 1023;

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  vga_char_seq_if bus ();
  vga_char_seq dut (.vga_clk(clk), .rst(rst), .bus(bus));

  logic [7:0]  ram   [0:4095];
  logic [7:0]  chars [0:4095];
  logic [15:0] pix_log [0:4095];
  logic [11:0] ra_log  [0:4095];
  logic [11:0] fa_log  [0:4095];
  logic [15:0] lit [0:7] = '{FG, BG, BG, FG, BG, BG, BG, FG};

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;

  logic        host_busy = 1'b0;
  logic        host_written = 1'b0;
  logic [11:0] host_addr = 12'd0;
  logic [7:0]  host_data = 8'd0;
  logic        rst_next = 1'b0;
  int host_t, we_seen, we_at, ack_seen, ack_at, exp_we_at;
  logic [11:0] we_addr_s;
  logic [7:0]  we_data_s;

  // Font ROM contents: a few pinned glyph rows, arithmetic filler elsewhere
  function automatic logic [7:0] font_fn(input logic [7:0] c, input logic [3:0] r);
    if (c == 8'hFF) return 8'hFF;
    if (c == 8'h41 && r == 4'd5) return 8'h91;
    return (c * 8'd29) ^ {r, r} ^ 8'h5A;
  endfunction

  function automatic bit is_slot(input int x, input int y, input logic en);
    return en && x < 640 && y < 480 && (x % 8) == 0;
  endfunction

  function automatic logic [15:0] pix_of(input int x, input int y, input logic en, input logic [7:0] c);
    logic [7:0] b;
    if (!en || x >= 640 || y >= 480) return BG;
    b = font_fn(c, 4'(y % 16));
    return b[7 - (x % 8)] ? FG : BG;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_no);
    end
  endtask

  // Environment: synchronous character RAM and font ROM
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
    bus.font_data <= font_fn(bus.font_addr[11:4], bus.font_addr[3:0]);
  end

  // Pixel checker: expected colour from the shadow map, compared three cycles on
  initial begin : monitor
    logic [15:0] hist [0:2];
    logic [7:0]  cur_char;
    logic [15:0] e;
    int x, y;
    cur_char = 8'd0;
    for (int i = 0; i < 3; i++) hist[i] = BG;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("pix_in_reset", 32'(bus.pix_data), 32'(BG));
        for (int i = 0; i < 3; i++) hist[i] = BG;
      end else begin
        x = int'(bus.pix_x);
        y = int'(bus.pix_y);
        if (is_slot(x, y, bus.disp_en)) begin
          cur_char = chars[(y / 16) * 80 + x / 8];
          chk("no_we_in_slot", 32'(bus.ram_we), 32'd0);
        end
        e = pix_of(x, y, bus.disp_en, cur_char);
        chk("pix", 32'(bus.pix_data), 32'(hist[2]));
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = e;
      end
    end
  end

  // One clock of stimulus; host write lands on the first non-slot cycle after req rises
  task automatic cyc(input int x, input int y, input logic en);
    @(posedge clk);
    #1;
    cyc_no++;
    bus.pix_x   = 10'(x);
    bus.pix_y   = 10'(y);
    bus.disp_en = en;
    bus.wr_req  = host_busy;
    bus.wr_addr = host_addr;
    bus.wr_data = host_data;
    if (!rst && host_busy && !host_written && cyc_no > host_t && !is_slot(x, y, en)) begin
      host_written = 1'b1;
      exp_we_at = cyc_no;
      if (int'(host_addr) < CELLS) chars[host_addr] = host_data;
    end
    if (rst_next) begin
      #2;
      rst = 1'b1;
      host_busy = 1'b0;
      rst_next = 1'b0;
    end
    @(negedge clk);
    pix_log[cyc_no] = bus.pix_data;
    ra_log[cyc_no]  = bus.ram_addr;
    fa_log[cyc_no]  = bus.font_addr;
    if (bus.ram_we) begin
      we_seen++;
      we_at = cyc_no;
      we_addr_s = bus.ram_addr;
      we_data_s = bus.ram_wdata;
    end
    if (bus.wr_ack) begin
      ack_seen++;
      ack_at = cyc_no;
      host_busy = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(IDLE_XY, IDLE_XY, 1'b1);
  endtask

  task automatic host_go(input int a, input logic [7:0] d);
    host_busy = 1'b1;
    host_written = 1'b0;
    host_addr = 12'(a);
    host_data = d;
    host_t = cyc_no + 1;
    we_seen = 0; ack_seen = 0; we_at = -1; ack_at = -1; exp_we_at = -1;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 20 && ack_seen == 0; i++) idle(1);
    idle(1);
  endtask

  task automatic check_write(input string nm, input int exp_we, input int we_lat, input int ack_lat);
    chk({nm, "_we_count"}, 32'(we_seen), 32'(exp_we));
    if (exp_we != 0) begin
      chk({nm, "_we_latency"}, 32'(we_at - host_t), 32'(we_lat));
      chk({nm, "_we_model"}, 32'(we_at), 32'(exp_we_at));
      chk({nm, "_we_addr"}, 32'(we_addr_s), 32'(host_addr));
      chk({nm, "_we_data"}, 32'(we_data_s), 32'(host_data));
    end
    chk({nm, "_ack_count"}, 32'(ack_seen), 32'd1);
    chk({nm, "_ack_latency"}, 32'(ack_at - host_t), 32'(ack_lat));
  endtask

  initial begin : watchdog
    #(40 * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, ts, tx, tl, td, tr, c;
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'd0;
      chars[i] = 8'd0;
    end
    rst = 1'b1;
    bus.pix_x = 10'(IDLE_XY); bus.pix_y = 10'(IDLE_XY); bus.disp_en = 1'b1;
    bus.wr_req = 1'b0; bus.wr_addr = 12'd0; bus.wr_data = 8'd0;

    // Reset with an active slot coordinate on the inputs
    cyc(8, 16, 1'b1);
    cyc(8, 16, 1'b1);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rst_font_addr", 32'(bus.font_addr), 32'd0);
    chk("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
    chk("rst_pix", 32'(bus.pix_data), 32'd0);
    idle(1);
    rst = 1'b0;
    idle(2);

    // Single glyph
    host_go(0, 8'h41);
    wait_ack();
    check_write("w0", 1, 1, 2);
    t0 = cyc_no + 1;
    for (int x = 0; x < 8; x++) cyc(x, 5, 1'b1);
    idle(4);
    chk("glyph_font_addr", 32'(fa_log[t0 + 1]), 32'h415);
    for (int k = 0; k < 8; k++) chk("glyph_pix", 32'(pix_log[t0 + 3 + k]), 32'(lit[k]));

    // Contention: request rises the cycle before the x=8 fetch slot
    ts = 0;
    for (int x = 0; x < 16; x++) begin
      if (x == 7) host_go(81, 8'h7E);
      if (x == 8) ts = cyc_no + 1;
      cyc(x, 20, 1'b1);
    end
    idle(2);
    check_write("w81", 1, 2, 3);
    chk("slot_ram_addr", 32'(ra_log[ts]), 32'd81);
    tx = 0;
    for (int x = 0; x < 24; x++) begin
      if (x == 8) tx = cyc_no + 1;
      cyc(x, 20, 1'b1);
    end
    idle(4);
    chk("raw_7e_bit7", 32'(pix_log[tx + 3]), 32'(BG));
    chk("raw_7e_bit6", 32'(pix_log[tx + 4]), 32'(FG));

    // Bounds
    host_go(CELLS, 8'h55);
    wait_ack();
    check_write("woob", 0, 0, 2);
    tx = cyc_no + 1;
    cyc(640, 0, 1'b1);
    cyc(0, 480, 1'b1);
    idle(4);
    chk("x640_no_fetch", 32'(ra_log[tx]), 32'd0);
    chk("y480_no_fetch", 32'(ra_log[tx + 1]), 32'd0);
    chk("x640_pix", 32'(pix_log[tx + 3]), 32'(BG));
    chk("y480_pix", 32'(pix_log[tx + 4]), 32'(BG));

    // Last cell with an all-ones glyph
    host_go(CELLS - 1, 8'hFF);
    wait_ack();
    check_write("wlast", 1, 1, 2);
    tl = cyc_no + 1;
    for (int y = 464; y < 480; y++)
      for (int x = 632; x <= 640; x++) cyc(x, y, 1'b1);
    idle(4);
    chk("last_ram_addr", 32'(ra_log[tl]), 32'd2399);
    for (int y = 464; y < 480; y++)
      for (int x = 632; x <= 640; x++) begin
        c = tl + (y - 464) * 9 + (x - 632);
        chk("last_cell_pix", 32'(pix_log[c + 3]), 32'(x < 640 ? FG : BG));
      end

    // Display disable, with a host write whose next cycle would be a slot
    for (int x = 0; x < 8; x++) cyc(x, 5, 1'b1);
    td = cyc_no + 1;
    for (int x = 8; x < 24; x++) begin
      if (x == 15) host_go(5, 8'h12);
      cyc(x, 5, 1'b0);
    end
    idle(4);
    check_write("wdis", 1, 1, 2);
    chk("dis_last_enabled_px", 32'(pix_log[td + 2]), 32'(FG));
    chk("dis_first_px", 32'(pix_log[td + 3]), 32'(BG));
    chk("dis_x12_px", 32'(pix_log[td + 7]), 32'(BG));

    // Reset while the host FSM is waiting out a fetch slot
    for (int x = 0; x < 7; x++) cyc(x, 0, 1'b1);
    host_go(3, 8'h33);
    cyc(7, 0, 1'b1);
    rst_next = 1'b1;
    cyc(8, 0, 1'b1);
    chk("midrst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("midrst_wr_ack", 32'(bus.wr_ack), 32'd0);
    chk("midrst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("midrst_font_addr", 32'(bus.font_addr), 32'd0);
    cyc(9, 0, 1'b1);
    idle(1);
    rst = 1'b0;
    idle(3);
    chk("midrst_no_write", 32'(we_seen), 32'd0);
    chk("midrst_no_ack", 32'(ack_seen), 32'd0);
    for (int x = 0; x < 32; x++) cyc(x, 0, 1'b1);
    for (int x = 0; x < 8; x++) cyc(x, 5, 1'b1);
    idle(4);

    // Host re-presents the abandoned write
    host_go(3, 8'h33);
    wait_ack();
    check_write("wre", 1, 1, 2);
    tr = cyc_no + 1;
    for (int x = 24; x < 32; x++) cyc(x, 2, 1'b1);
    idle(4);
    chk("re_font_addr", 32'(fa_log[tr + 1]), 32'h332);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
